// File: rtl/qei_sample_ctrl.sv
// qei_sample_ctrl: windowed sampler and byte-serial record readout for a QEI counter.
//
// Every window (BASE_CYCLES << period_sel enabled clocks) the live position is
// captured together with a saturated signed 8-bit velocity (counts per window),
// the live direction and a 6-bit sequence number. On request, one consistent
// 4-byte record is shifted out over an 8-bit valid/ack port.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   ena           enables the window timer (readout keeps running when low)
//   count         live position count, two's-complement wrap
//   dir           live direction (1 = forward)
//   period_sel    window length select, applied at the next window start
//   rd_req        single-cycle readout request, ignored while busy
//   byte_data     current record byte (byte0 = pos[7:0] first)
//   byte_valid    byte_data valid
//   byte_ack      consumer accepts byte when byte_valid & byte_ack
//   busy          readout in progress
//   sample_pulse  one-cycle strobe after each snapshot
module qei_sample_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BASE_CYCLES = 1024,
  parameter int unsigned TMR_W       = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [CNT_W-1:0] count,
  input  logic             dir,
  input  logic [1:0]       period_sel,
  input  logic             rd_req,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ack,
  output logic             busy,
  output logic             sample_pulse
);

  localparam int unsigned SEQ_W = 6;
  localparam int unsigned REC_W = 32;

  localparam logic signed [CNT_W-1:0] VEL_MAX = CNT_W'(127);
  localparam logic signed [CNT_W-1:0] VEL_MIN = CNT_W'(-128);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Window timer and snapshot registers
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] win_last_q;
  logic [CNT_W-1:0] pos_snap_q;
  logic [CNT_W-1:0] prev_cnt_q;
  logic [7:0]       vel_q;
  logic             sat_q;
  logic             dir_snap_q;
  logic [SEQ_W-1:0] seq_q;
  logic             sample_pulse_q;

  // Readout registers
  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [REC_W-1:0] shadow_q, shadow_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             busy_q, busy_d;

  logic [TMR_W-1:0]        win_last_sel_c;
  logic                    terminal_c;
  logic signed [CNT_W-1:0] delta_c;
  logic [7:0]              vel_c;
  logic                    sat_c;
  logic [REC_W-1:0]        record_c;

  // Last timer value of a window for the currently selected period
  always_comb begin
    win_last_sel_c = TMR_W'(BASE_CYCLES - 32'd1);
    case (period_sel)
      2'd1:    win_last_sel_c = TMR_W'((BASE_CYCLES << 1) - 32'd1);
      2'd2:    win_last_sel_c = TMR_W'((BASE_CYCLES << 2) - 32'd1);
      2'd3:    win_last_sel_c = TMR_W'((BASE_CYCLES << 3) - 32'd1);
      default: win_last_sel_c = TMR_W'(BASE_CYCLES - 32'd1);
    endcase
  end

  // A paused timer sitting on its last value does not end the window
  assign terminal_c = ena && (timer_q == win_last_q);

  // Modular difference reinterpreted as signed, then clamped to 8 bits
  always_comb begin
    delta_c = count - prev_cnt_q;
    vel_c   = delta_c[7:0];
    sat_c   = 1'b0;
    if (delta_c > VEL_MAX) begin
      vel_c = 8'h7F;
      sat_c = 1'b1;
    end else if (delta_c < VEL_MIN) begin
      vel_c = 8'h80;
      sat_c = 1'b1;
    end
  end

  assign record_c = {sat_q, dir_snap_q, seq_q, vel_q, 16'(pos_snap_q)};

  // Window timer and snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q        <= '0;
      win_last_q     <= win_last_sel_c;
      pos_snap_q     <= '0;
      prev_cnt_q     <= '0;
      vel_q          <= '0;
      sat_q          <= 1'b0;
      dir_snap_q     <= 1'b0;
      seq_q          <= '0;
      sample_pulse_q <= 1'b0;
    end else begin
      sample_pulse_q <= terminal_c;
      if (terminal_c) begin
        timer_q    <= '0;
        win_last_q <= win_last_sel_c;
        pos_snap_q <= count;
        prev_cnt_q <= count;
        vel_q      <= vel_c;
        sat_q      <= sat_c;
        dir_snap_q <= dir;
        seq_q      <= seq_q + SEQ_W'(1);
      end else if (ena) begin
        timer_q <= timer_q + TMR_W'(1);
      end
    end
  end

  // Readout state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Readout next state; outputs are registered from the next-state values
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shadow_d = record_c;
        idx_d    = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (byte_valid_q && byte_ack) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d       = (state_d != ST_IDLE);
    byte_valid_d = (state_d == ST_SEND);
    byte_data_d  = byte_valid_d ? shadow_d[{idx_d, 3'b000} +: 8] : 8'h00;
  end

  assign byte_data    = byte_data_q;
  assign byte_valid   = byte_valid_q;
  assign busy         = busy_q;
  assign sample_pulse = sample_pulse_q;

endmodule
